// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// datapath select codes and the internal control-word layout.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EX1    = 3'd2,
        ST_EX2    = 3'd3,
        ST_HALT   = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam int OP_ADDI = 0;
    localparam int OP_SW   = 1;
    localparam int OP_JAL  = 2;
    localparam int OP_BIN  = 3;
    localparam int OP_ORM  = 4;
    localparam int OP_SPC  = 5;
    localparam int OP_LWA  = 6;
    localparam int OP_OUT  = 7;
    localparam int OP_HALT = 15;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_SP   = 2'b01;
    localparam logic [1:0] SRCA_ACC  = 2'b10;

    localparam logic [1:0] SRCB_IMM  = 2'b00;
    localparam logic [1:0] SRCB_OFS  = 2'b01;
    localparam logic [1:0] SRCB_ONE  = 2'b10;
    localparam logic [1:0] SRCB_MEM  = 2'b11;

    localparam logic [1:0] PCSRC_JUMP   = 2'b00;
    localparam logic [1:0] PCSRC_ALU    = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;

    localparam logic [1:0] ACCSRC_ALU = 2'b00;
    localparam logic [1:0] ACCSRC_MEM = 2'b10;

    localparam logic [1:0] MADDR_PC  = 2'b00;
    localparam logic [1:0] MADDR_IMM = 2'b01;
    localparam logic [1:0] MADDR_SP  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b010;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       acc_write;
        logic       sp_write;
        logic       mem_write;
        logic       mem_out_write;
        logic       out_write;
        logic       branch_cycle;
        logic       sign_ext;
        logic       sp_src;
        logic       mem_data;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] acc_src;
        logic [1:0] mem_addr;
        logic [1:0] branch_cond;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input int op);
        return (op >= OP_ADDI) && (op <= OP_OUT);
    endfunction

    // Opcodes whose EX1 touches memory and therefore stretches by MEM_LAT.
    function automatic logic is_mem_op(input int op);
        return (op == OP_SW) || (op == OP_JAL) || (op == OP_ORM) ||
               (op == OP_SPC) || (op == OP_LWA);
    endfunction

    function automatic logic is_two_phase_op(input int op);
        return (op == OP_ORM) || (op == OP_SPC);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Controller <-> datapath bundle: the controller is the master and drives
// every enable/select; the datapath returns the instruction and branch flag.
interface multicycle_ctrl_unit_if #(
    parameter int IW    = 16,
    parameter int CNT_W = 16
);
    logic [IW-1:0]    IROut;
    logic             DoBranch;

    logic             IRWrite;
    logic             PCWrite;
    logic             ACCWrite;
    logic             SPWrite;
    logic             MemWrite;
    logic             MemOutWrite;
    logic             OutWrite;
    logic             BranchCycle;
    logic             SignExt;
    logic             SPSrc;
    logic             MemData;

    logic [1:0]       PCSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ACCSrc;
    logic [1:0]       MemAddr;
    logic [1:0]       BranchCond;
    logic [2:0]       ALUOp;

    logic             Halted;
    logic             Trap;
    logic [CNT_W-1:0] Retired;

    modport master (
        input  IROut, DoBranch,
        output IRWrite, PCWrite, ACCWrite, SPWrite, MemWrite, MemOutWrite,
               OutWrite, BranchCycle, SignExt, SPSrc, MemData,
               PCSrc, ALUSrcA, ALUSrcB, ACCSrc, MemAddr, BranchCond, ALUOp,
               Halted, Trap, Retired
    );

    modport slave (
        output IROut, DoBranch,
        input  IRWrite, PCWrite, ACCWrite, SPWrite, MemWrite, MemOutWrite,
               OutWrite, BranchCycle, SignExt, SPSrc, MemData,
               PCSrc, ALUSrcA, ALUSrcB, ACCSrc, MemAddr, BranchCond, ALUOp,
               Halted, Trap, Retired
    );

endinterface

// File: rtl/ctrl_wait_counter.sv
// 4-bit dwell counter for memory-access states; done marks the final
// cycle (count == MEM_LAT), clear reloads zero on every state entry.
module ctrl_wait_counter #(
    parameter int MEM_LAT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic done_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 4'(MEM_LAT));

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle accumulator-machine controller: Moore FSM over FETCH/DECODE/
// EX1/EX2 with memory-latency stretching, HALT/TRAP sinks and a retire count.
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int IW      = 16,
    parameter int OPW     = 4,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_ctrl_unit_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl;
    int               opcode;
    logic             mem_state;
    logic             wait_done;
    logic             last_cycle;
    logic             retire;
    logic             wr_ok;
    logic             unused_ir;

    assign opcode    = int'(bus.IROut[IW-1:IW-OPW]);
    assign unused_ir = ^bus.IROut[IW-OPW-3:0];

    assign mem_state  = (state_q == ST_FETCH) ||
                        ((state_q == ST_EX1) && is_mem_op(opcode));
    assign last_cycle = !mem_state || wait_done;

    ctrl_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear_i (last_cycle),
        .inc_i   (!last_cycle),
        .done_o  (wait_done)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (last_cycle) begin
            case (state_q)
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state_d = ST_HALT;
                    end else if (is_legal_op(opcode)) begin
                        state_d = ST_EX1;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
                ST_EX1:    state_d = is_two_phase_op(opcode) ? ST_EX2 : ST_FETCH;
                ST_EX2:    state_d = ST_FETCH;
                ST_HALT,
                ST_TRAP:   state_d = state_q;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    assign retire = last_cycle && (state_d == ST_FETCH) &&
                    ((state_q == ST_EX1) || (state_q == ST_EX2));

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_addr  = MADDR_PC;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRCA_SP;
                ctrl.alu_src_b = SRCB_OFS;
                ctrl.sign_ext  = 1'b1;
            end
            ST_EX1: begin
                case (opcode)
                    OP_ADDI: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.alu_src_a = SRCA_ACC;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.sign_ext  = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.acc_src   = ACCSRC_ALU;
                    end
                    OP_SW: begin
                        ctrl.mem_write = 1'b1;
                        ctrl.mem_addr  = MADDR_IMM;
                        ctrl.mem_data  = 1'b0;
                    end
                    OP_JAL: begin
                        ctrl.mem_write = 1'b1;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_src    = PCSRC_JUMP;
                        ctrl.mem_data  = 1'b1;
                        ctrl.mem_addr  = MADDR_SP;
                    end
                    OP_BIN: begin
                        // Condition field sits directly below the opcode.
                        ctrl.branch_cycle = 1'b1;
                        ctrl.pc_src       = PCSRC_BRANCH;
                        ctrl.branch_cond  = bus.IROut[IW-OPW-1:IW-OPW-2];
                        ctrl.pc_write     = bus.DoBranch;
                    end
                    OP_ORM, OP_SPC: begin
                        ctrl.mem_out_write = 1'b1;
                        ctrl.mem_addr      = MADDR_IMM;
                    end
                    OP_LWA: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.mem_addr  = MADDR_IMM;
                        ctrl.acc_src   = ACCSRC_MEM;
                    end
                    OP_OUT: ctrl.out_write = 1'b1;
                    default: ;
                endcase
            end
            ST_EX2: begin
                if (opcode == OP_ORM) begin
                    ctrl.acc_write = 1'b1;
                    ctrl.alu_src_a = SRCA_ACC;
                    ctrl.alu_src_b = SRCB_MEM;
                    ctrl.acc_src   = ACCSRC_ALU;
                    ctrl.alu_op    = ALU_OR;
                end else begin
                    ctrl.sp_write  = 1'b1;
                    ctrl.alu_src_a = SRCA_SP;
                    ctrl.alu_src_b = SRCB_MEM;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.sp_src    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Enables fire only in a state's last cycle and never while reset is held.
    assign wr_ok = last_cycle && !reset;

    assign bus.IRWrite     = ctrl.ir_write      && wr_ok;
    assign bus.PCWrite     = ctrl.pc_write      && wr_ok;
    assign bus.ACCWrite    = ctrl.acc_write     && wr_ok;
    assign bus.SPWrite     = ctrl.sp_write      && wr_ok;
    assign bus.MemWrite    = ctrl.mem_write     && wr_ok;
    assign bus.MemOutWrite = ctrl.mem_out_write && wr_ok;
    assign bus.OutWrite    = ctrl.out_write     && wr_ok;

    assign bus.BranchCycle = ctrl.branch_cycle;
    assign bus.SignExt     = ctrl.sign_ext;
    assign bus.SPSrc       = ctrl.sp_src;
    assign bus.MemData     = ctrl.mem_data;
    assign bus.PCSrc       = ctrl.pc_src;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ACCSrc      = ctrl.acc_src;
    assign bus.MemAddr     = ctrl.mem_addr;
    assign bus.BranchCond  = ctrl.branch_cond;
    assign bus.ALUOp       = ctrl.alu_op;

    assign bus.Halted      = (state_q == ST_HALT);
    assign bus.Trap        = (state_q == ST_TRAP);
    assign bus.Retired     = retired_q;

endmodule

// File: doc/multicycle_ctrl_unit.md
MULTICYCLE_CTRL_UNIT -- requirements
Module: multicycle_ctrl_unit

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width (IW >= 16).
REQ-002 SHALL have parameter OPW, default 4, opcode width; opcode = IR[IW-1:IW-OPW].
REQ-003 SHALL have parameter MEM_LAT, default 0, extra wait cycles per memory-access state (0..15).
REQ-004 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 IROut  in  IW  current instruction register contents.
REQ-008 DoBranch  in  1  branch condition met (from comparator).
REQ-009 IRWrite, PCWrite, ACCWrite, SPWrite, MemWrite, MemOutWrite, OutWrite, BranchCycle, SignExt, SPSrc, MemData  out  1 each  datapath enables/selects.
REQ-010 PCSrc, ALUSrcA, ALUSrcB, ACCSrc, MemAddr, BranchCond  out  2 each  datapath selects.
REQ-011 ALUOp  out  3  ALU operation.
REQ-012 Halted  out  1  HALT executed; Trap  out  1  illegal opcode seen.
REQ-013 Retired  out  CNT_W  instructions completed since reset.

Function
REQ-014 States: FETCH, DECODE, EX1, EX2, HALT, TRAP; outputs are Moore functions of state, opcode and wait counter.
REQ-015 Opcodes: ADDI=0, SW=1, JAL=2, BIN=3, ORM=4, SPC=5, LWA=6, OUT=7, HALT=15; all others illegal.
REQ-016 Unlisted outputs SHALL be 0 in every state.
REQ-017 FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, PCSrc=01, ALUOp=000, MemAddr=00; -> DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, SignExt=1; legal -> EX1, HALT opcode -> HALT, illegal -> TRAP.
REQ-019 EX1 ADDI: ACCWrite=1, ALUSrcA=10, ALUSrcB=00, SignExt=1, ALUOp=000, ACCSrc=00; -> FETCH.
REQ-020 EX1 SW: MemWrite=1, MemAddr=01, MemData=0; -> FETCH.
REQ-021 EX1 JAL: MemWrite=1, PCWrite=1, PCSrc=00, MemData=1, MemAddr=10; -> FETCH.
REQ-022 EX1 BIN: BranchCycle=1, PCSrc=10, BranchCond=IROut[IW-OPW-1:IW-OPW-2]; PCWrite = DoBranch; -> FETCH.
REQ-023 EX1 ORM/SPC: MemOutWrite=1, MemAddr=01; -> EX2.
REQ-024 EX2 ORM: ACCWrite=1, ALUSrcA=10, ALUSrcB=11, ACCSrc=00, ALUOp=010; -> FETCH.
REQ-025 EX2 SPC: SPWrite=1, ALUSrcA=01, ALUSrcB=11, ALUOp=000, SPSrc=1; -> FETCH.
REQ-026 EX1 LWA: ACCWrite=1, MemAddr=01, ACCSrc=10; EX1 OUT: OutWrite=1; both -> FETCH.
REQ-027 Memory-access states (FETCH, EX1 of SW/JAL/ORM/SPC/LWA) SHALL last MEM_LAT+1 cycles; selects (MemAddr, MemData, PCSrc, ALUSrc*, ACCSrc) held throughout; write enables (IRWrite, PCWrite, MemWrite, MemOutWrite, ACCWrite) asserted only in final cycle.
REQ-028 Wait counter SHALL be 4 bits, cleared on every state entry.
REQ-029 Retired SHALL increment by 1 on each transition into FETCH from EX1/EX2, wrapping at 2^CNT_W to 0.
REQ-030 HALT and TRAP SHALL be absorbing until reset; all enables 0; Halted/Trap held 1.
REQ-031 Total latency with MEM_LAT=0: ADDI/SW/JAL/BIN/LWA/OUT 3 cycles, ORM/SPC 4 cycles.

Reset
REQ-032 reset=1 SHALL force state FETCH, wait counter 0, Retired 0, Halted 0, Trap 0 immediately, independent of clk.
REQ-033 While reset=1 all write enables SHALL be 0; selects take FETCH values.
REQ-034 Reset mid-instruction SHALL abandon it without incrementing Retired; first rising edge after deassertion executes FETCH's final cycle.

Structure
REQ-035 Opcode constants, state encoding and select-code constants SHALL live in shared package ctrl_pkg.
REQ-036 Wait counter SHALL be a sub-module ctrl_wait_counter (load-zero, increment, done = count==MEM_LAT).

Verification
REQ-037 MEM_LAT=0, IROut=ADDI: FETCH/DECODE/EX1 values per REQ-017..019 on 3 consecutive cycles; Retired 0->1.
REQ-038 MEM_LAT=2, IROut=SW: EX1 lasts 3 cycles, MemAddr=01 throughout, MemWrite=1 only cycle 3.
REQ-039 BIN with DoBranch=0 then 1: BranchCycle=1, PCSrc=10, PCWrite 0 then 1.
REQ-040 ORM then SPC: 4 cycles each, EX2 values per REQ-024/025; Retired +2.
REQ-041 IROut opcode 9: TRAP after DECODE, Trap=1, all enables 0 for 20 cycles; reset clears Trap asynchronously.
REQ-042 CNT_W=2, 5 ADDIs: Retired sequence 1,2,3,0,1.
